// File: rtl/io_port_gen.sv
// General-purpose I/O port with PINx/DDRx/PORTx registers and a masked pin-change interrupt.
// Pads are synchronised through s1/s2; s3 keeps the previous s2 so edges can be detected.
module io_port_gen #(
  parameter int         P_WIDTH    = 8,
  parameter logic [5:0] PINX_ADDR  = 6'h03,
  parameter logic [5:0] DDRX_ADDR  = 6'h04,
  parameter logic [5:0] PORTX_ADDR = 6'h05,
  parameter logic [5:0] PCMSK_ADDR = 6'h0C,
  parameter logic [5:0] PCSR_ADDR  = 6'h0D
) (
  input  logic               cp2,
  input  logic               ireset,
  input  logic [5:0]         IO_Addr,
  input  logic               iore,
  input  logic               iowe,
  input  logic [7:0]         dbus_in,
  output logic [7:0]         dbus_out,
  output logic               out_en,
  input  logic [P_WIDTH-1:0] pin_i,
  output logic [P_WIDTH-1:0] portx,
  output logic [P_WIDTH-1:0] ddrx,
  output logic [P_WIDTH-1:0] pin_sync,
  input  logic               pcint_ack,
  output logic               pcint_irq
);

  logic [P_WIDTH-1:0] s1, s2, s3;
  logic [P_WIDTH-1:0] pcmsk;
  logic [P_WIDTH-1:0] chg;
  logic               pcif, pcie;
  logic               wr_pin, wr_ddr, wr_port, wr_msk, wr_pcsr, pcif_clr;

  // Zero-extend a port-wide value onto the 8-bit data bus.
  function automatic logic [7:0] zext(input logic [P_WIDTH-1:0] v);
    logic [7:0] r;
    r = '0;
    r[P_WIDTH-1:0] = v;
    return r;
  endfunction

  assign wr_pin   = iowe && (IO_Addr == PINX_ADDR);
  assign wr_ddr   = iowe && (IO_Addr == DDRX_ADDR);
  assign wr_port  = iowe && (IO_Addr == PORTX_ADDR);
  assign wr_msk   = iowe && (IO_Addr == PCMSK_ADDR);
  assign wr_pcsr  = iowe && (IO_Addr == PCSR_ADDR);
  assign pcif_clr = (wr_pcsr && dbus_in[0]) || pcint_ack;

  // Uses the mask already held, so a PCMSK write only affects later cycles.
  assign chg       = (s2 ^ s3) & pcmsk;
  assign pin_sync  = s2;
  assign pcint_irq = pcif & pcie;

  always_ff @(posedge cp2 or negedge ireset) begin
    if (!ireset) begin
      s1    <= '0;
      s2    <= '0;
      s3    <= '0;
      portx <= '0;
      ddrx  <= '0;
      pcmsk <= '0;
      pcif  <= 1'b0;
      pcie  <= 1'b0;
    end else begin
      // stage 1-3: synchroniser and edge history
      s1 <= pin_i;
      s2 <= s1;
      s3 <= s2;
      if (wr_port)
        portx <= dbus_in[P_WIDTH-1:0];
      else if (wr_pin)
        portx <= portx ^ dbus_in[P_WIDTH-1:0];
      if (wr_ddr)
        ddrx <= dbus_in[P_WIDTH-1:0];
      if (wr_msk)
        pcmsk <= dbus_in[P_WIDTH-1:0];
      if (wr_pcsr)
        pcie <= dbus_in[1];
      // A new event beats any simultaneous clear.
      if (|chg)
        pcif <= 1'b1;
      else if (pcif_clr)
        pcif <= 1'b0;
    end
  end

  always_comb begin
    dbus_out = 8'h00;
    out_en   = 1'b0;
    if (iore) begin
      if (IO_Addr == PINX_ADDR) begin
        dbus_out = zext(s2);
        out_en   = 1'b1;
      end else if (IO_Addr == DDRX_ADDR) begin
        dbus_out = zext(ddrx);
        out_en   = 1'b1;
      end else if (IO_Addr == PORTX_ADDR) begin
        dbus_out = zext(portx);
        out_en   = 1'b1;
      end else if (IO_Addr == PCMSK_ADDR) begin
        dbus_out = zext(pcmsk);
        out_en   = 1'b1;
      end else if (IO_Addr == PCSR_ADDR) begin
        dbus_out = {6'b0, pcie, pcif};
        out_en   = 1'b1;
      end
    end
  end

endmodule
